// File: rtl/vid_ctl_pkg.sv
// Shared constants for the MDA/CGA I/O front-end: port offsets inside the
// 16-port window, status byte layouts and the helpers that assemble them.
package vid_ctl_pkg;

  // Offsets inside the I/O window (0-7 belong to the CRTC)
  localparam logic [3:0] OFF_MODE     = 4'h8;
  localparam logic [3:0] OFF_COLOR    = 4'h9;
  localparam logic [3:0] OFF_STATUS   = 4'hA;
  localparam logic [3:0] OFF_LPEN_CLR = 4'hB;
  localparam logic [3:0] OFF_LPEN_SET = 4'hC;

  // Status byte layout selectors
  localparam int STATUS_MDA = 0;
  localparam int STATUS_CGA = 1;

  // Upper nibble of the status byte always reads as ones
  localparam logic [7:0] STATUS_FIXED_HI = 8'hF0;

  // MDA status bit positions
  localparam int ST_MDA_HSYNC = 0;
  localparam int ST_MDA_VIDEO = 3;

  // CGA status bit positions
  localparam int ST_CGA_NOT_DE     = 0;
  localparam int ST_CGA_LPEN_LATCH = 1;
  localparam int ST_CGA_LPEN_SW    = 2;
  localparam int ST_CGA_VSYNC      = 3;

  function automatic logic [7:0] status_mda(input logic video, input logic hsync);
    logic [7:0] s;
    s = STATUS_FIXED_HI;
    s[ST_MDA_VIDEO] = video;
    s[ST_MDA_HSYNC] = hsync;
    return s;
  endfunction

  function automatic logic [7:0] status_cga(input logic vsync, input logic lpen_sw,
                                            input logic lpen_latch, input logic de);
    logic [7:0] s;
    s = STATUS_FIXED_HI;
    s[ST_CGA_VSYNC]      = vsync;
    s[ST_CGA_LPEN_SW]    = lpen_sw;
    s[ST_CGA_LPEN_LATCH] = lpen_latch;
    s[ST_CGA_NOT_DE]     = ~de;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with edge detection on
// the synchronised level. RESET_VAL lets an active-low strobe reset to its
// "asserted" level so an assertion already in progress at reset is ignored.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Shift the raw input through the synchroniser and keep the last level for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign level = stages[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/vid_ctl_regs.sv
// ISA I/O front-end and timing control for MDA/CGA-class adapters: window
// decode, CRTC strobes, mode/colour registers, status byte, light pen latch
// and frame-locked blink. Optional build macro VID_CTL_VSYNC_APPLY_EN defers
// mode register writes to the next synchronised vsync rising edge.
module vid_ctl_regs
  import vid_ctl_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR    = 20'h003B0,
  parameter int          STATUS_MODE  = 0,
  parameter logic [7:0]  MODE_RESET   = 8'h28,
  parameter int          BLINK_FRAMES = 8,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] bus_a,
  input  logic        bus_ior_l,
  input  logic        bus_iow_l,
  input  logic        bus_aen,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        crtc_cs,
  output logic        crtc_write,
  output logic        crtc_read,
  input  logic [7:0]  crtc_dout,
  output logic        crtc_lpen_strobe,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        display_enable_in,
  input  logic        video_in,
  input  logic        lpen_in,
  input  logic        lpen_sw,
  output logic [7:0]  mode_reg,
  output logic [7:0]  color_reg,
  output logic        hsync_out,
  output logic        blink_cursor,
  output logic        blink_char
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic       sel;
  logic [3:0] off;
  logic       iow_level, iow_rise, iow_fall;
  logic       ior_level, ior_rise, ior_fall;
  logic       lpen_level, lpen_rise, lpen_fall;
  logic       vsync_level, vsync_rise, vsync_fall;
  logic       wr_pulse, mode_wr, color_wr, lpen_clr, lpen_set;
  logic       lpen_latch;
  logic [7:0] frame_cnt;
  logic [7:0] status_byte;
  logic       unused_sync;

  assign sel     = (bus_a[19:4] == BASE_ADDR[19:4]) & ~bus_aen;
  assign off     = bus_a[3:0];
  assign crtc_cs = sel & ~off[3];

  // IOW resets to its asserted level so a write in progress at reset never strobes
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_iow (
    .clk(clk), .reset(reset), .d(bus_iow_l),
    .level(iow_level), .rise(iow_rise), .fall(iow_fall));

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ior (
    .clk(clk), .reset(reset), .d(bus_ior_l),
    .level(ior_level), .rise(ior_rise), .fall(ior_fall));

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lpen (
    .clk(clk), .reset(reset), .d(lpen_in),
    .level(lpen_level), .rise(lpen_rise), .fall(lpen_fall));

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_vsync (
    .clk(clk), .reset(reset), .d(vsync_in),
    .level(vsync_level), .rise(vsync_rise), .fall(vsync_fall));

  assign unused_sync = &{1'b0, iow_level, iow_rise, ior_rise, ior_fall,
                         lpen_level, lpen_fall, vsync_level, vsync_fall};

  assign wr_pulse  = iow_fall;
  assign mode_wr   = wr_pulse & sel & (off == OFF_MODE);
  assign color_wr  = wr_pulse & sel & (off == OFF_COLOR);
  assign lpen_clr  = wr_pulse & sel & (off == OFF_LPEN_CLR);
  assign lpen_set  = lpen_rise | (wr_pulse & sel & (off == OFF_LPEN_SET));
  assign crtc_read = ~ior_level & crtc_cs;
  assign hsync_out = hsync_in & mode_reg[3];

  // Registered CRTC write strobe, one clock per synchronised IOW assertion
  always_ff @(posedge clk) begin
    if (reset) crtc_write <= 1'b0;
    else       crtc_write <= wr_pulse & crtc_cs;
  end

`ifdef VID_CTL_VSYNC_APPLY_EN
  logic [7:0] mode_pend;
  logic       mode_pend_valid;

  // Mode writes park in a pending register and land on the next vsync edge; a write in the same clock waits for the following edge
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg        <= MODE_RESET;
      mode_pend       <= 8'h00;
      mode_pend_valid <= 1'b0;
    end else begin
      if (vsync_rise && mode_pend_valid) begin
        mode_reg        <= mode_pend;
        mode_pend_valid <= 1'b0;
      end
      if (mode_wr) begin
        mode_pend       <= bus_d;
        mode_pend_valid <= 1'b1;
      end
    end
  end
`else
  // Mode register loads directly from the bus on the write pulse
  always_ff @(posedge clk) begin
    if (reset)        mode_reg <= MODE_RESET;
    else if (mode_wr) mode_reg <= bus_d;
  end
`endif

  // Colour select register loads directly from the bus on the write pulse
  always_ff @(posedge clk) begin
    if (reset)         color_reg <= 8'h00;
    else if (color_wr) color_reg <= bus_d;
  end

  // Light pen latch with set priority over clear; strobe the CRTC only when the latch first sets
  always_ff @(posedge clk) begin
    if (reset) begin
      lpen_latch       <= 1'b0;
      crtc_lpen_strobe <= 1'b0;
    end else begin
      crtc_lpen_strobe <= lpen_set & ~lpen_latch;
      if (lpen_set)      lpen_latch <= 1'b1;
      else if (lpen_clr) lpen_latch <= 1'b0;
    end
  end

  // Count vsync edges; each wrap toggles the cursor, each cursor fall toggles the character blink
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= 8'h00;
      blink_cursor <= 1'b0;
      blink_char   <= 1'b0;
    end else if (vsync_rise) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt    <= 8'h00;
        blink_cursor <= ~blink_cursor;
        if (blink_cursor) blink_char <= ~blink_char;
      end else begin
        frame_cnt <= frame_cnt + 8'h01;
      end
    end
  end

  assign status_byte = (STATUS_MODE == STATUS_CGA)
                       ? status_cga(vsync_in, lpen_sw, lpen_latch, display_enable_in)
                       : status_mda(video_in, hsync_in);

  assign bus_dir = ~bus_ior_l & sel & (crtc_cs | (off == OFF_STATUS));

  // Read data mux: status port, odd CRTC register data port, otherwise zero
  always_comb begin
    bus_out = 8'h00;
    if (sel && (off == OFF_STATUS)) bus_out = status_byte;
    else if (crtc_cs && off[0])     bus_out = crtc_dout;
  end

endmodule

// File: tb/tb_vid_ctl_regs.sv
// Directed bench for vid_ctl_regs: an MDA instance at 3B0 and a CGA instance
// at 3D0 share the ISA pins; a behavioural model is compared every cycle.
module tb_vid_ctl_regs;

  localparam int          SYNC       = 2;
  localparam logic [19:0] BASE_MDA   = 20'h003B0;
  localparam logic [19:0] BASE_CGA   = 20'h003D0;
  localparam int          FRAMES_MDA = 2;
  localparam int          FRAMES_CGA = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] bus_a;
  logic        bus_ior_l, bus_iow_l, bus_aen;
  logic [7:0]  bus_d, crtc_dout;
  logic        hsync_in, vsync_in, display_enable_in, video_in, lpen_in, lpen_sw;

  logic [7:0]  bus_out_m, mode_m, color_m, bus_out_c, mode_c, color_c;
  logic        dir_m, cs_m, wr_m, rd_m, stb_m, hs_m, cur_m, chr_m;
  logic        dir_c, cs_c, wr_c, rd_c, stb_c, hs_c, cur_c, chr_c;

  int   vec_count = 0;
  int   fail_count = 0;
  bit   check_en = 0;
  int   wr_cnt_m = 0;
  int   stb_cnt_c = 0;

  logic [7:0] m_mode [2];
  logic [7:0] m_color [2];
  logic [7:0] m_pend_val [2];
  bit         m_pend [2];
  bit         m_lpen [2];
  bit         m_cur [2];
  bit         m_chr [2];
  bit         m_wr [2];
  bit         m_stb [2];
  int         m_frames [2];
  bit         m_rd_sync;

  always #5 clk = ~clk;

  vid_ctl_regs #(.BASE_ADDR(BASE_MDA), .STATUS_MODE(0), .MODE_RESET(8'h28),
                 .BLINK_FRAMES(FRAMES_MDA), .SYNC_STAGES(SYNC)) dut_mda (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(bus_out_m), .bus_dir(dir_m),
    .crtc_cs(cs_m), .crtc_write(wr_m), .crtc_read(rd_m), .crtc_dout(crtc_dout),
    .crtc_lpen_strobe(stb_m), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_enable_in(display_enable_in), .video_in(video_in), .lpen_in(lpen_in),
    .lpen_sw(lpen_sw), .mode_reg(mode_m), .color_reg(color_m), .hsync_out(hs_m),
    .blink_cursor(cur_m), .blink_char(chr_m));

  vid_ctl_regs #(.BASE_ADDR(BASE_CGA), .STATUS_MODE(1), .MODE_RESET(8'h28),
                 .BLINK_FRAMES(FRAMES_CGA), .SYNC_STAGES(SYNC)) dut_cga (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(bus_out_c), .bus_dir(dir_c),
    .crtc_cs(cs_c), .crtc_write(wr_c), .crtc_read(rd_c), .crtc_dout(crtc_dout),
    .crtc_lpen_strobe(stb_c), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_enable_in(display_enable_in), .video_in(video_in), .lpen_in(lpen_in),
    .lpen_sw(lpen_sw), .mode_reg(mode_c), .color_reg(color_c), .hsync_out(hs_c),
    .blink_cursor(cur_c), .blink_char(chr_c));

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] base_of(input int i);
    return (i == 0) ? BASE_MDA : BASE_CGA;
  endfunction

  function automatic int inst_of(input logic [19:0] addr);
    logic [19:0] bm, bc;
    bm = BASE_MDA;
    bc = BASE_CGA;
    if (addr[19:4] == bm[19:4]) return 0;
    if (addr[19:4] == bc[19:4]) return 1;
    return -1;
  endfunction

  // Model outputs from the pins and the model registers, then compare one instance
  task automatic checkOutput(input int i, input logic [7:0] mode_a, color_a, out_a,
                             input logic dir_a, cs_a, wr_a, rd_a, stb_a, hs_a, cur_a, chr_a);
    logic [19:0] b;
    logic [3:0]  off;
    logic        sel_e, cs_e, dir_e;
    logic [7:0]  st_e, out_e;
    string       s;
    b     = base_of(i);
    off   = bus_a[3:0];
    sel_e = (bus_a[19:4] == b[19:4]) && !bus_aen;
    cs_e  = sel_e && (off < 4'd8);
    if (i == 0) st_e = {4'hF, video_in, 2'b00, hsync_in};
    else        st_e = {4'hF, vsync_in, lpen_sw, m_lpen[1], ~display_enable_in};
    out_e = 8'h00;
    if (sel_e && off == 4'hA)      out_e = st_e;
    else if (cs_e && off[0])       out_e = crtc_dout;
    dir_e = !bus_ior_l && sel_e && (cs_e || off == 4'hA);
    s = (i == 0) ? "mda" : "cga";
    cmp({s, "_mode"},    mode_a,  m_mode[i]);
    cmp({s, "_color"},   color_a, m_color[i]);
    cmp({s, "_bus_out"}, out_a,   out_e);
    cmp({s, "_bus_dir"}, dir_a,   dir_e);
    cmp({s, "_crtc_cs"}, cs_a,    cs_e);
    cmp({s, "_crtc_wr"}, wr_a,    m_wr[i]);
    cmp({s, "_crtc_rd"}, rd_a,    m_rd_sync & cs_e);
    cmp({s, "_lpen_stb"}, stb_a,  m_stb[i]);
    cmp({s, "_hsync_out"}, hs_a,  hsync_in & m_mode[i][3]);
    cmp({s, "_blink_cur"}, cur_a, m_cur[i]);
    cmp({s, "_blink_chr"}, chr_a, m_chr[i]);
  endtask

  // Every-cycle comparison on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput(0, mode_m, color_m, bus_out_m, dir_m, cs_m, wr_m, rd_m, stb_m, hs_m, cur_m, chr_m);
      checkOutput(1, mode_c, color_c, bus_out_c, dir_c, cs_c, wr_c, rd_c, stb_c, hs_c, cur_c, chr_c);
      if (wr_m)  wr_cnt_m++;
      if (stb_c) stb_cnt_c++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ior_l, input logic iow_l,
                               input logic [19:0] addr, input logic [7:0] data);
    bus_ior_l = ior_l;
    bus_iow_l = iow_l;
    bus_a     = addr;
    bus_d     = data;
  endtask

  // An IOW becomes visible three clocks after the pin falls (two sync flops plus the update clock)
  task automatic io_write(input logic [19:0] addr, input logic [7:0] data, input int hold);
    int i;
    logic [3:0] off;
    i   = inst_of(addr);
    off = addr[3:0];
    applyStimulus(1'b1, 1'b0, addr, data);
    step(SYNC + 1);
    if (i >= 0) begin
      if (off == 4'h8) begin
`ifdef VID_CTL_VSYNC_APPLY_EN
        m_pend_val[i] = data;
        m_pend[i]     = 1'b1;
`else
        m_mode[i] = data;
`endif
      end
      else if (off == 4'h9) m_color[i] = data;
      else if (off == 4'hB) m_lpen[i] = 1'b0;
      else if (off == 4'hC) begin
        m_stb[i]  = !m_lpen[i];
        m_lpen[i] = 1'b1;
      end
      else if (off < 4'd8) m_wr[i] = 1'b1;
    end
    step(1);
    for (int k = 0; k < 2; k++) begin
      m_wr[k]  = 1'b0;
      m_stb[k] = 1'b0;
    end
    if (hold > SYNC + 2) step(hold - (SYNC + 2));
    applyStimulus(1'b1, 1'b1, addr, data);
    step(SYNC + 2);
  endtask

  task automatic read_start(input logic [19:0] addr);
    applyStimulus(1'b0, 1'b1, addr, bus_d);
    step(SYNC);
    m_rd_sync = 1'b1;
  endtask

  task automatic read_end();
    bus_ior_l = 1'b1;
    step(SYNC);
    m_rd_sync = 1'b0;
    step(1);
  endtask

  // One vsync pulse; blink state advances by the frame-count arithmetic
  task automatic vsync_pulse();
    int frames;
    vsync_in = 1'b1;
    step(SYNC + 1);
    for (int i = 0; i < 2; i++) begin
      frames = (i == 0) ? FRAMES_MDA : FRAMES_CGA;
      m_frames[i]++;
      if (m_frames[i] == frames) begin
        m_frames[i] = 0;
        if (m_cur[i]) m_chr[i] = !m_chr[i];
        m_cur[i] = !m_cur[i];
      end
`ifdef VID_CTL_VSYNC_APPLY_EN
      if (m_pend[i]) begin
        m_mode[i] = m_pend_val[i];
        m_pend[i] = 1'b0;
      end
`endif
    end
    step(2);
    vsync_in = 1'b0;
    step(SYNC + 2);
  endtask

  task automatic lpen_pulse();
    lpen_in = 1'b1;
    step(SYNC + 1);
    for (int i = 0; i < 2; i++) begin
      m_stb[i]  = !m_lpen[i];
      m_lpen[i] = 1'b1;
    end
    step(1);
    for (int i = 0; i < 2; i++) m_stb[i] = 1'b0;
    lpen_in = 1'b0;
    step(SYNC + 2);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 8'h28; m_color[i] = 8'h00; m_pend_val[i] = 8'h00; m_pend[i] = 0;
      m_lpen[i] = 0; m_cur[i] = 0; m_chr[i] = 0; m_wr[i] = 0; m_stb[i] = 0; m_frames[i] = 0;
    end
    m_rd_sync = 0;
    reset = 1'b1;
    bus_aen = 1'b0; crtc_dout = 8'h00;
    hsync_in = 0; vsync_in = 0; display_enable_in = 1; video_in = 0; lpen_in = 0; lpen_sw = 1;
    applyStimulus(1'b1, 1'b0, 20'h003B8, 8'h55);
    step(3);
    reset    = 1'b0;
    check_en = 1'b1;
    $display("[TB] reset released with IOW held low");
    step(6);
    cmp("rst_mode_lit", mode_m, 8'h28);
    cmp("rst_color_lit", color_c, 8'h00);
    bus_iow_l = 1'b1;
    step(SYNC + 2);

    hsync_in = 1'b1;
    step(2);
    cmp("hsync_out_lit", hs_m, 1'b1);

    io_write(20'h003B8, 8'h09, 10);
`ifdef VID_CTL_VSYNC_APPLY_EN
    cmp("mode_wr_lit", mode_m, 8'h28);
`else
    cmp("mode_wr_lit", mode_m, 8'h09);
`endif

    video_in = 1'b1;
    read_start(20'h003BA);
    cmp("status_mda_lit", bus_out_m, 8'hF9);
    cmp("status_dir_lit", dir_m, 1'b1);
    read_end();
    bus_aen = 1'b1;
    read_start(20'h003BA);
    cmp("aen_dir_lit", dir_m, 1'b0);
    cmp("aen_out_lit", bus_out_m, 8'h00);
    read_end();
    bus_aen = 1'b0;

    crtc_dout = 8'h5A;
    read_start(20'h003B5);
    cmp("crtc_data_lit", bus_out_m, 8'h5A);
    read_end();
    read_start(20'h003B4);
    cmp("crtc_idx_out_lit", bus_out_m, 8'h00);
    cmp("crtc_idx_dir_lit", dir_m, 1'b1);
    read_end();

    wr_cnt_m = 0;
    io_write(20'h003B4, 8'h77, 30);
    cmp("crtc_write_count", 8'(wr_cnt_m), 8'd1);

    io_write(20'h003B9, 8'h3C, 6);
    io_write(20'h003D9, 8'h0A, 6);
    io_write(20'h003D8, 8'h01, 6);

    for (int k = 1; k <= 8; k++) begin
      vsync_pulse();
      if (k == 2) cmp("blink_e2_cur_lit", cur_m, 1'b1);
      if (k == 4) begin
        cmp("blink_e4_cur_lit", cur_m, 1'b0);
        cmp("blink_e4_chr_lit", chr_m, 1'b1);
      end
    end
    cmp("blink_e8_cur_lit", cur_m, 1'b0);
    cmp("blink_e8_chr_lit", chr_m, 1'b0);
    cmp("cga_e8_cur_lit", cur_c, 1'b0);
    cmp("cga_e8_chr_lit", chr_c, 1'b1);
    cmp("cga_mode_lit", mode_c, 8'h01);
    cmp("cga_hsync_mask_lit", hs_c, 1'b0);

    stb_cnt_c = 0;
    lpen_pulse();
    read_start(20'h003DA);
    cmp("cga_lpen_set_lit", bus_out_c, 8'hF6);
    read_end();
    lpen_pulse();
    cmp("lpen_strobe_count", 8'(stb_cnt_c), 8'd1);
    io_write(20'h003DB, 8'hFF, 6);
    read_start(20'h003DA);
    cmp("cga_lpen_clr_lit", bus_out_c, 8'hF4);
    read_end();
    io_write(20'h003DC, 8'h00, 6);
    cmp("lpen_strobe_count2", 8'(stb_cnt_c), 8'd2);

    io_write(20'h003B8, 8'h01, 6);
    io_write(20'h003B8, 8'h29, 6);
`ifdef VID_CTL_VSYNC_APPLY_EN
    cmp("mode_pending_lit", mode_m, 8'h09);
`else
    cmp("mode_pending_lit", mode_m, 8'h29);
`endif
    vsync_pulse();
    cmp("mode_applied_lit", mode_m, 8'h29);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/vid_ctl_regs.md
Name: vid_ctl_regs

Overview:
- Parametrised ISA I/O front-end and timing-control block for the MDA/CGA-class display adapters.
- Decodes a 16-port I/O window and hands the CRTC its chip-select, write strobe and read data.
- Holds the mode-control and colour-select registers, builds the adapter status byte (MDA or CGA layout), latches the light pen and generates frame-locked cursor/character blink.
- Replaces ad-hoc per-adapter decode and the free-running blink counter; sits between the ISA pins and crtc6845 / pixel pipeline.

Parameters:
- BASE_ADDR, 20'h003B0, I/O window base; low 4 bits must be zero (3B0 MDA, 3D0 CGA).
- STATUS_MODE, 0, status byte layout: 0 = MDA, 1 = CGA.
- MODE_RESET, 8'h28, mode register value after reset.
- BLINK_FRAMES, 8, vsync rising edges per cursor-blink toggle; valid range 1..255.
- SYNC_STAGES, 2, synchroniser depth for asynchronous inputs; valid range 2..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bus_a  in  20  ISA address.
- bus_ior_l  in  1  ISA I/O read, active low, asynchronous.
- bus_iow_l  in  1  ISA I/O write, active low, asynchronous.
- bus_aen  in  1  DMA address enable; high blocks all decode.
- bus_d  in  8  ISA write data.
- bus_out  out  8  ISA read data.
- bus_dir  out  1  high while this block drives a read.
- crtc_cs  out  1  offsets 0-7 selected.
- crtc_write  out  1  one-clk CRTC write strobe.
- crtc_read  out  1  synchronised read level to CRTC.
- crtc_dout  in  8  CRTC register read data.
- crtc_lpen_strobe  out  1  one-clk pulse telling the CRTC to capture its address.
- hsync_in, vsync_in, display_enable_in, video_in  in  1 each  raw CRTC/pixel timing.
- lpen_in  in  1  light pen trigger, asynchronous.
- lpen_sw  in  1  light pen switch.
- mode_reg  out  8  mode control register.
- color_reg  out  8  colour select register.
- hsync_out  out  1  hsync_in AND mode_reg[3].
- blink_cursor  out  1  cursor blink phase.
- blink_char  out  1  character blink phase.

Behaviour:
- Decode (combinational, raw pins):
  - sel = (bus_a[19:4] == BASE_ADDR[19:4]) & ~bus_aen; off = bus_a[3:0].
  - crtc_cs = sel & (off < 8).
- Port map by off:
  - 8: mode, write.
  - 9: colour, write.
  - A: status, read.
  - B: clear light pen latch, write, data ignored.
  - C: set light pen latch, write, data ignored.
  - Others ignored.
- Read path (combinational):
  - bus_dir = ~bus_ior_l & sel & (crtc_cs | off == A).
  - bus_out = status when off == A; crtc_dout when crtc_cs & off[0]; otherwise 8'h00.
- Write path:
  - bus_iow_l passes through SYNC_STAGES flops; the falling edge of the synchronised signal gives exactly one wr_pulse per IOW assertion.
  - Address and data are sampled on wr_pulse.
  - crtc_write = wr_pulse & crtc_cs, registered, so it rises 1 clk after wr_pulse.
  - crtc_read = synchronised ~bus_ior_l & crtc_cs.
- Registers after reset: mode_reg = MODE_RESET; color_reg = 0; lpen latch = 0; blink outputs = 0; counters = 0; all strobes = 0.
- Register updates: mode_reg and color_reg update the clk after wr_pulse.
- Status byte:
  - MDA layout: {4'hF, video_in, 2'b00, hsync_in}.
  - CGA layout: {4'hF, vsync_in, lpen_sw, lpen_latch, ~display_enable_in}.
- Light pen:
  - lpen_in is synchronised; its rising edge, or a write to C, sets lpen_latch.
  - crtc_lpen_strobe pulses 1 clk only on a 0→1 transition of the latch.
  - A write to B clears the latch.
  - Clear and set in the same clk: set wins.
- Blink:
  - vsync_in is synchronised; its rising edge increments frame_cnt (width 8).
  - At frame_cnt == BLINK_FRAMES-1: frame_cnt wraps to 0 and blink_cursor toggles.
  - blink_char toggles on every second blink_cursor falling edge... no: on every blink_cursor 1→0 transition, giving half the cursor rate.
- Reset mid-IOW: no wr_pulse is generated until bus_iow_l has been seen high after reset.

Optional Feature:
- Macro VID_CTL_VSYNC_APPLY_EN.
- Defined: mode writes go to a pending register plus pending flag. mode_reg loads the pending value on the synchronised vsync_in rising edge. A later write before vsync overwrites the pending value (last one wins). A write on the same clk as the vsync edge is applied at the next vsync.
- Undefined: mode_reg updates immediately, as described above.

Decomposition:
- Package vid_ctl_pkg: port offsets (OFF_MODE = 8, OFF_COLOR = 9, OFF_STATUS = A, OFF_LPEN_CLR = B, OFF_LPEN_SET = C), STATUS_MDA / STATUS_CGA constants, status bit positions.
- Sub-module sync_edge (parameter SYNC_STAGES; outputs level, rise, fall), instantiated for iow, ior, lpen_in and vsync_in.

Test Plan:
- Reset, then IOW to 3B8 with 8'h09 held 10 clks → mode_reg = 8'h09 after exactly one update; hsync_out follows hsync_in.
- IOR 3BA, STATUS_MODE = 0, video_in = 1, hsync_in = 1 → bus_out = 8'hF9, bus_dir = 1. Repeat with bus_aen = 1 → bus_dir = 0, bus_out = 8'h00.
- IOR 3B5 with crtc_dout = 8'h5A → bus_out = 8'h5A. IOR 3B4 → bus_out = 8'h00 with bus_dir = 1.
- IOW 3B4 → exactly one crtc_write pulse with crtc_cs = 1, even for a 30-clk IOW.
- BLINK_FRAMES = 2, 8 vsync edges → blink_cursor toggles at edges 2/4/6/8; blink_char = 1 after edge 4, returns to 0 after edge 8.
- STATUS_MODE = 1: lpen_in rise → one crtc_lpen_strobe, status bit1 = 1; second lpen_in rise → no strobe; IOW 3BB → bit1 = 0.
- With VID_CTL_VSYNC_APPLY_EN: writes 8'h01 then 8'h29 before vsync → mode_reg unchanged until the vsync edge, then 8'h29.
